// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Purpose : Shared definitions for the data-memory arbiter: default widths,
//           the starvation threshold default, the arbiter state encoding and
//           a helper that sizes the starvation counter.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W     = 32;
  localparam int DMEM_DATA_W     = 32;
  localparam int DMEM_STARVE_MAX = 8;

  // Two states today; the 2-bit encoding leaves room for more.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,  // core owns the memory
    ARB_LOCK = 2'b01   // aux owns the memory
  } arb_state_t;

  // Width needed to count from 0 up to max_val inclusive.
  function automatic int starve_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_starve_cnt
// Purpose : Saturating count of consecutive idle-state cycles in which the
//           aux requester was denied. When the count reaches STARVE_MAX the
//           aux requester is forced through for one beat.
// Ports   : clk, rst (async, active-low)
//           idle        - arbiter is in its core-owned state
//           aux_valid   - aux request present
//           aux_ready   - aux beat accepted this cycle
//           force_grant - override core priority this cycle
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic aux_valid,
  input  logic aux_ready,
  output logic force_grant
);

  localparam int               CNT_W = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Any completed beat (forced or not) restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (aux_valid && aux_ready) begin
      r_cnt <= '0;
    end else if (idle && aux_valid && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign force_grant = (r_cnt == C_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Shares the single-port data memory between the pipeline memory
//           stage (core, fixed priority) and an auxiliary requester that may
//           lock the memory for multi-beat transfers. While the aux side
//           holds the memory, core_stall freezes the pipeline.
// Ports   : clk, rst (async, active-low)
//           core_req/we/addr/wdata -> core_rdata (comb), core_stall
//           aux_valid/we/lock/addr/wdata -> aux_ready, aux_rvalid, aux_rdata
//           mem_we/addr/wd -> dmem, mem_rd <- dmem (async read)
// Options : DMEM_ARB_STARVE_GUARD_EN - when defined, a starvation counter
//           forces one aux beat after STARVE_MAX denied idle cycles.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              aux_valid,
  input  logic              aux_we,
  input  logic              aux_lock,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ready,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_idle;
  logic              w_force;
  logic              w_grant_aux;
  logic              w_grant_core;
  logic              w_beat;
  logic              r_aux_rvalid;
  logic [DATA_W-1:0] r_aux_rdata;

  assign w_idle = (r_state == ARB_IDLE);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk         (clk),
    .rst         (rst),
    .idle        (w_idle),
    .aux_valid   (aux_valid),
    .aux_ready   (aux_ready),
    .force_grant (w_force)
  );
`else
  // Strict core priority: the override can never assert. STARVE_MAX is
  // referenced only so the parameter list is the same in both builds.
  assign w_force = (STARVE_MAX < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants, memory mux, handshake outputs and next state. Grants are
  // qualified with rst so nothing is accepted or written while in reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_aux  = 1'b0;
    w_grant_core = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wd       = '0;

    w_grant_aux  = rst & ((r_state == ARB_LOCK) |
                          (w_idle & aux_valid & (~core_req | w_force)));
    w_grant_core = rst & core_req & ~w_grant_aux;

    if (w_grant_aux) begin
      mem_addr = aux_addr;
      mem_wd   = aux_wdata;
      mem_we   = aux_valid & aux_we;
    end else if (w_grant_core) begin
      mem_addr = core_addr;
      mem_wd   = core_wdata;
      mem_we   = core_we;
    end

    case (r_state)
      ARB_IDLE: if (w_beat && aux_lock) w_state_nxt = ARB_LOCK;
      // Ownership is released on the first cycle lock drops, beat or not.
      ARB_LOCK: if (!aux_lock)          w_state_nxt = ARB_IDLE;
      default:                          w_state_nxt = ARB_IDLE;
    endcase
  end

  assign aux_ready  = w_grant_aux & aux_valid;
  assign w_beat     = aux_valid & aux_ready;
  assign core_stall = core_req & w_grant_aux;
  assign core_rdata = mem_rd;

  // Registered aux read response; data holds until the next read beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aux_rvalid <= 1'b0;
      r_aux_rdata  <= '0;
    end else begin
      r_aux_rvalid <= w_beat & ~aux_we;
      if (w_beat && !aux_we) begin
        r_aux_rdata <= mem_rd;
      end
    end
  end

  assign aux_rvalid = r_aux_rvalid;
  assign aux_rdata  = r_aux_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Purpose : Self-checking bench for dmem_arbiter. A small word memory backs
//           mem_rd; a transaction-level reference model predicts every
//           output each cycle from the arbitration rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef logic [31:0] mem_t [0:63];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < 64; i++) m[i] = 32'hA500_0000 ^ (i * 32'h9E37_79B1);
    return m;
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, aux_valid, aux_we, aux_lock;
  logic [AW-1:0] core_addr, aux_addr, mem_addr;
  logic [DW-1:0] core_wdata, aux_wdata, core_rdata, aux_rdata, mem_wd, mem_rd;
  logic          core_stall, aux_ready, aux_rvalid, mem_we;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .aux_valid(aux_valid), .aux_we(aux_we), .aux_lock(aux_lock),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_ready(aux_ready),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Environment memory seen by the DUT.
  mem_t mem = init_mem();
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wd;

  // Reference model state.
  mem_t        ref_mem = init_mem();
  bit          m_lock;
  int          m_starve;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int ready_seen, stall_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_starve = 0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // One clock cycle: apply inputs, check all outputs against the model,
  // then advance the model at the rising edge.
  task automatic cycle(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic av, input logic aw,
                       input logic al, input logic [31:0] aa, input logic [31:0] ad);
    bit          frc, aux_g, core_g, e_ready, e_stall, e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    aux_valid = av; aux_we = aw; aux_lock = al; aux_addr = aa; aux_wdata = ad;
    #1;
    frc     = GUARD && !m_lock && (m_starve == SMAX);
    aux_g   = m_lock || (av && (!cr || frc));
    core_g  = cr && !aux_g;
    e_ready = aux_g && av;
    e_stall = cr && aux_g;
    e_we    = core_g ? cw : (e_ready && aw);
    e_addr  = aux_g ? aa : (core_g ? ca : 32'h0);
    e_wd    = aux_g ? ad : (core_g ? cd : 32'h0);
    check_eq("aux_ready", {31'b0, aux_ready}, {31'b0, e_ready});
    check_eq("core_stall", {31'b0, core_stall}, {31'b0, e_stall});
    check_eq("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wd", mem_wd, e_wd);
    check_eq("aux_rvalid", {31'b0, aux_rvalid}, {31'b0, m_rvalid});
    check_eq("aux_rdata", aux_rdata, m_rdata);
    if (core_g) check_eq("core_rdata", core_rdata, ref_mem[ca[7:2]]);
    if (e_ready) ready_seen++;
    if (e_stall) stall_seen++;
    @(posedge clk);
    m_rvalid = e_ready && !aw;
    if (m_rvalid) m_rdata = ref_mem[aa[7:2]];
    if (e_we) ref_mem[e_addr[7:2]] = e_wd;
    if (e_ready) m_starve = 0;
    else if (!m_lock && av && m_starve < SMAX) m_starve++;
    if (m_lock) m_lock = al;
    else if (e_ready && al) m_lock = 1'b1;
  endtask

  function automatic logic [31:0] raddr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    rst = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = '0; core_wdata = '0;
    aux_valid = 1'b1; aux_we = 1'b1; aux_lock = 1'b1; aux_addr = '0; aux_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", {31'b0, core_stall}, 32'h0);
    check_eq("rst_ready", {31'b0, aux_ready}, 32'h0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check_eq("rst_rvalid", {31'b0, aux_rvalid}, 32'h0);
    #1 rst = 1'b1;

    // Simultaneous requests: core wins, aux follows next cycle.
    cycle(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 32'h1234_5678);
    cycle(0, 0, 32'h10, 0, 1, 1, 0, 32'h20, 32'h1234_5678);
    cycle(1, 0, 32'h20, 0, 0, 0, 0, 32'h0, 32'h0);

    // Aux write then read, response one cycle later.
    cycle(0, 0, 0, 0, 1, 1, 0, 32'h40, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 0, 1, 0, 0, 32'h40, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check_eq("rd_deadbeef", aux_rdata, 32'hDEAD_BEEF);

    // Locked 4-beat burst while the core keeps requesting.
    cycle(0, 0, 0, 0, 1, 0, 1, 32'h80, 32'h0);
    stall_seen = 0;
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 32'h44, 0, 1, 1, (i < 3), 32'(i * 4), 32'h100 + 32'(i));
    check_eq("burst_stalls", 32'(stall_seen), 32'd4);
    cycle(1, 0, 32'h8, 0, 0, 0, 0, 32'h0, 32'h0);

    // Lock held with no aux traffic: memory idles, core stays stalled.
    cycle(0, 0, 0, 0, 1, 1, 1, 32'h50, 32'h55);
    stall_seen = 0;
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h60, 32'h66, 0, 1, 1, 32'h50, 32'h77);
    check_eq("idle_lock_stalls", 32'(stall_seen), 32'd3);
    cycle(1, 0, 32'h60, 0, 0, 0, 0, 32'h0, 32'h0);

    // Continuous contention: aux starves unless the guard is built in.
    cycle(0, 0, 0, 0, 1, 1, 0, 32'h70, 32'h7);
    ready_seen = 0;
    for (int i = 0; i < 18; i++) cycle(1, 0, 32'h4, 0, 1, 1, 0, 32'h74, 32'(i));
    check_eq("starve_grants", 32'(ready_seen), GUARD ? 32'd2 : 32'd0);

    // Reset mid-lock with a read response in flight.
    cycle(0, 0, 0, 0, 1, 0, 1, 32'h40, 32'h0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_rvalid", {31'b0, aux_rvalid}, 32'h0);
    check_eq("mid_rst_rdata", aux_rdata, 32'h0);
    check_eq("mid_rst_stall", {31'b0, core_stall}, 32'h0);
    check_eq("mid_rst_mem_we", {31'b0, mem_we}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 32'h0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr(), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), raddr(), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
